// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared op encoding and request decode for the LIFO stack
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } lifo_op_e;

  typedef struct packed {
    lifo_op_e op;
    logic     ovf;
    logic     unf;
  } lifo_dec_t;

  // Both enables while empty still store the data but flag the missing pop.
  function automatic lifo_dec_t lifo_decode(input logic wr_en, input logic rd_en,
                                            input logic empty, input logic full);
    lifo_dec_t d;
    d.op  = OP_IDLE;
    d.ovf = 1'b0;
    d.unf = 1'b0;
    if (wr_en && rd_en) begin
      if (empty) begin
        d.op  = OP_PUSH;
        d.unf = 1'b1;
      end else begin
        d.op = OP_SWAP;
      end
    end else if (wr_en) begin
      if (full) d.ovf = 1'b1;
      else      d.op  = OP_PUSH;
    end else if (rd_en) begin
      if (empty) d.unf = 1'b1;
      else       d.op  = OP_POP;
    end
    return d;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// rtl/lifo_stack_if.sv - request/response bundle between a LIFO user and the stack
interface lifo_stack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 5
);
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  wr_en;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] peek_data;
  logic                  lifo_full;
  logic                  lifo_empty;
  logic                  lifo_almost_full;
  logic                  lifo_almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_wr, wr_en, rd_en, clr_err,
    input  data_rd, rd_valid, peek_data, lifo_full, lifo_empty,
           lifo_almost_full, lifo_almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_wr, wr_en, rd_en, clr_err,
    output data_rd, rd_valid, peek_data, lifo_full, lifo_empty,
           lifo_almost_full, lifo_almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/lifo_ram.sv
// rtl/lifo_ram.sv - unreset register array, one write port and two async read ports
module lifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         pop_addr,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic [AW-1:0]         peek_addr,
  output logic [DATA_WIDTH-1:0] peek_data
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign pop_data  = mem_q[pop_addr];
  assign peek_data = mem_q[peek_addr];
endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with swap, peek, occupancy flags and sticky errors
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input logic        clk,
  input logic        rst,
  lifo_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  // The occupancy count doubles as the stack pointer: next free slot.
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  empty, full;
  lifo_dec_t             dec;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic [AW-1:0]         top_addr;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [DATA_WIDTH-1:0] peek_data;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign top_addr = AW'(cnt_q - CNT_W'(1));

  always_comb begin
    dec        = lifo_decode(bus.wr_en, bus.rd_en, empty, full);
    cnt_d      = cnt_q;
    data_rd_d  = data_rd_q;
    rd_valid_d = 1'b0;
    ovf_d      = bus.clr_err ? 1'b0 : ovf_q;
    unf_d      = bus.clr_err ? 1'b0 : unf_q;
    ram_we     = 1'b0;
    ram_waddr  = AW'(cnt_q);
    if (dec.ovf) ovf_d = 1'b1;
    if (dec.unf) unf_d = 1'b1;
    case (dec.op)
      OP_PUSH: begin
        ram_we = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      OP_POP: begin
        data_rd_d  = pop_data;
        rd_valid_d = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
      end
      OP_SWAP: begin
        data_rd_d  = pop_data;
        rd_valid_d = 1'b1;
        ram_we     = 1'b1;
        ram_waddr  = top_addr;
      end
      default: ;
    endcase
    // Reset must also suppress the storage write requested in the same cycle.
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      data_rd_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      data_rd_q  <= data_rd_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  lifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk      (clk),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (bus.data_wr),
    .pop_addr (top_addr),
    .pop_data (pop_data),
    .peek_addr(top_addr),
    .peek_data(peek_data)
  );

  assign bus.data_rd           = data_rd_q;
  assign bus.rd_valid          = rd_valid_q;
  assign bus.peek_data         = peek_data;
  assign bus.count             = cnt_q;
  assign bus.lifo_empty        = empty;
  assign bus.lifo_full         = full;
  assign bus.lifo_almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
  assign bus.lifo_almost_empty = (cnt_q <= CNT_W'(AE_THRESH));
  assign bus.overflow          = ovf_q;
  assign bus.underflow         = unf_q;
endmodule
